av_mailbox_slave: RTL and testbench

//  Avalon-MM slave (responder) that lets a Qsys-side master (Nios/JTAG) exchange 16-bit words with the MCU.
//  Two FIFOs: a2m (Avalon->MCU) and m2a (MCU->Avalon).
//  The MCU side plugs into the register bus like fduart: a show-ahead rx register plus a load-strobed tx register.

---
 rtl/av_mailbox_slave_if.sv | 14 +
 rtl/av_mailbox_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_av_mailbox_slave.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/av_mailbox_slave_if.sv
// Avalon-MM bus bundle between a Qsys-side master and the av_mailbox_slave responder.
interface av_mailbox_slave_if;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [15:0] s_writedata;
  logic [15:0] s_readdata;
  logic        s_waitrequest;

  modport master (output s_address, s_read, s_write, s_writedata,
                  input  s_readdata, s_waitrequest);
  modport slave  (input  s_address, s_read, s_write, s_writedata,
                  output s_readdata, s_waitrequest);
endinterface

// File: rtl/av_mailbox_slave.sv
// Avalon-MM mailbox responder: a2m / m2a word FIFOs between a Qsys master and the MCU register bus.
// Optional AV_MAILBOX_IRQ_EN adds the s_irq output and a live IRQCTL enable bit.
module av_mailbox_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                sysclk,
  input  logic                sysreset_n,
  av_mailbox_slave_if.slave   bus,
  output logic [15:0]         mcu_rx_data,
  input  logic                mcu_rx_read,
  output logic                mcu_rx_empty,
  input  logic [15:0]         mcu_tx_data,
  input  logic                mcu_tx_load,
  output logic                mcu_tx_full,
  output logic [15:0]         status_out
`ifdef AV_MAILBOX_IRQ_EN
  ,
  output logic                s_irq
`endif
);

  // state | meaning
  // IDLE  | no access in flight; a request moves to WAIT
  // WAIT  | inserting wait states; readdata captured on the way out
  // ACK   | waitrequest low for one cycle; side effect commits at its end
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rd_pop_q, rd_pop_d;
  logic [15:0]     scratch_q, scratch_d;
  logic            irq_en_q, irq_en_d;
  logic            a2m_ovf_q, a2m_ovf_d, m2a_unf_q, m2a_unf_d, mcu_ovf_q, mcu_ovf_d;

  logic [15:0]     a2m_mem_q [DEPTH];
  logic [15:0]     m2a_mem_q [DEPTH];
  logic [AW-1:0]   a2m_wr_q, a2m_wr_d, a2m_rd_q, a2m_rd_d;
  logic [AW-1:0]   m2a_wr_q, m2a_wr_d, m2a_rd_q, m2a_rd_d;
  logic [AW:0]     a2m_cnt_q, a2m_cnt_d, m2a_cnt_q, m2a_cnt_d;
  logic            a2m_empty_q, a2m_empty_d, a2m_full_q, a2m_full_d;
  logic            m2a_empty_q, m2a_empty_d, m2a_full_q, m2a_full_d;

  logic            is_wr, is_rd, commit;
  logic            av_data_wr, av_data_rd, av_stat_wr, av_scr_wr, av_irq_wr;
  logic            a2m_pop, a2m_push_ok, m2a_pop, m2a_push_ok;
  logic [15:0]     status, cap_data, irqctl_rd;
  logic            cap_pop;

  // Simultaneous read+write is treated as a write
  assign is_wr  = bus.s_write;
  assign is_rd  = bus.s_read && !bus.s_write;
  assign commit = (state_q == ACK);

  assign av_data_wr = commit && is_wr && (bus.s_address == 2'd0);
  assign av_data_rd = commit && is_rd && (bus.s_address == 2'd0);
  assign av_stat_wr = commit && is_wr && (bus.s_address == 2'd1);
  assign av_scr_wr  = commit && is_wr && (bus.s_address == 2'd2);
  assign av_irq_wr  = commit && is_wr && (bus.s_address == 2'd3);

  assign status = {8'(m2a_cnt_q), 1'b0, mcu_ovf_q, m2a_unf_q, a2m_ovf_q,
                   m2a_full_q, m2a_empty_q, a2m_full_q, a2m_empty_q};

`ifdef AV_MAILBOX_IRQ_EN
  logic s_irq_q, s_irq_d;
  assign irqctl_rd = {15'd0, irq_en_q};
  assign s_irq_d   = irq_en_q && !m2a_empty_q;
  assign s_irq     = s_irq_q;
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) s_irq_q <= 1'b0;
    else             s_irq_q <= s_irq_d;
  end
`else
  assign irqctl_rd = 16'd0;
`endif

  always_comb begin
    cap_data = 16'd0;
    cap_pop  = 1'b0;
    if (is_rd) begin
      unique case (bus.s_address)
        2'd0: begin
          // Remember whether the pop is real so ACK stays consistent with readdata
          cap_pop = !m2a_empty_q;
          if (!m2a_empty_q) cap_data = m2a_mem_q[m2a_rd_q];
        end
        2'd1:    cap_data = status;
        2'd2:    cap_data = scratch_q;
        default: cap_data = irqctl_rd;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rd_pop_d = rd_pop_q;
    unique case (state_q)
      IDLE: if (bus.s_read || bus.s_write) begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: if (cnt_q == '0) begin
        state_d  = ACK;
        rdata_d  = cap_data;
        rd_pop_d = cap_pop;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_readdata    = rdata_q;
  assign bus.s_waitrequest = (bus.s_read || bus.s_write) && (state_q != ACK);

  always_comb begin
    a2m_pop     = mcu_rx_read && !a2m_empty_q;
    a2m_push_ok = av_data_wr && (!a2m_full_q || a2m_pop);
    m2a_pop     = av_data_rd && rd_pop_q;
    m2a_push_ok = mcu_tx_load && (!m2a_full_q || m2a_pop);

    a2m_wr_d  = a2m_push_ok ? a2m_wr_q + PTR_ONE : a2m_wr_q;
    a2m_rd_d  = a2m_pop     ? a2m_rd_q + PTR_ONE : a2m_rd_q;
    m2a_wr_d  = m2a_push_ok ? m2a_wr_q + PTR_ONE : m2a_wr_q;
    m2a_rd_d  = m2a_pop     ? m2a_rd_q + PTR_ONE : m2a_rd_q;

    a2m_cnt_d = a2m_cnt_q;
    if (a2m_push_ok && !a2m_pop)      a2m_cnt_d = a2m_cnt_q + LVL_ONE;
    else if (!a2m_push_ok && a2m_pop) a2m_cnt_d = a2m_cnt_q - LVL_ONE;
    m2a_cnt_d = m2a_cnt_q;
    if (m2a_push_ok && !m2a_pop)      m2a_cnt_d = m2a_cnt_q + LVL_ONE;
    else if (!m2a_push_ok && m2a_pop) m2a_cnt_d = m2a_cnt_q - LVL_ONE;

    a2m_empty_d = (a2m_cnt_d == '0);
    a2m_full_d  = (a2m_cnt_d == LVL_FULL);
    m2a_empty_d = (m2a_cnt_d == '0);
    m2a_full_d  = (m2a_cnt_d == LVL_FULL);

    // Sticky set takes priority over a same-cycle write-1-to-clear
    a2m_ovf_d = (av_data_wr && a2m_full_q && !a2m_pop) ||
                (a2m_ovf_q && !(av_stat_wr && bus.s_writedata[4]));
    m2a_unf_d = (av_data_rd && !rd_pop_q) ||
                (m2a_unf_q && !(av_stat_wr && bus.s_writedata[5]));
    mcu_ovf_d = (mcu_tx_load && m2a_full_q && !m2a_pop) ||
                (mcu_ovf_q && !(av_stat_wr && bus.s_writedata[6]));

    scratch_d = av_scr_wr ? bus.s_writedata : scratch_q;
`ifdef AV_MAILBOX_IRQ_EN
    irq_en_d  = av_irq_wr ? bus.s_writedata[0] : irq_en_q;
`else
    irq_en_d  = 1'b0 & av_irq_wr;
`endif
  end

  assign mcu_rx_empty = a2m_empty_q;
  assign mcu_rx_data  = a2m_empty_q ? 16'd0 : a2m_mem_q[a2m_rd_q];
  assign mcu_tx_full  = m2a_full_q;
  assign status_out   = status;

  always_ff @(posedge sysclk) begin
    if (a2m_push_ok) a2m_mem_q[a2m_wr_q] <= bus.s_writedata;
    if (m2a_push_ok) m2a_mem_q[m2a_wr_q] <= mcu_tx_data;
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      rd_pop_q    <= 1'b0;
      scratch_q   <= '0;
      irq_en_q    <= 1'b0;
      a2m_ovf_q   <= 1'b0;
      m2a_unf_q   <= 1'b0;
      mcu_ovf_q   <= 1'b0;
      a2m_wr_q    <= '0;
      a2m_rd_q    <= '0;
      m2a_wr_q    <= '0;
      m2a_rd_q    <= '0;
      a2m_cnt_q   <= '0;
      m2a_cnt_q   <= '0;
      a2m_empty_q <= 1'b1;
      a2m_full_q  <= 1'b0;
      m2a_empty_q <= 1'b1;
      m2a_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rd_pop_q    <= rd_pop_d;
      scratch_q   <= scratch_d;
      irq_en_q    <= irq_en_d;
      a2m_ovf_q   <= a2m_ovf_d;
      m2a_unf_q   <= m2a_unf_d;
      mcu_ovf_q   <= mcu_ovf_d;
      a2m_wr_q    <= a2m_wr_d;
      a2m_rd_q    <= a2m_rd_d;
      m2a_wr_q    <= m2a_wr_d;
      m2a_rd_q    <= m2a_rd_d;
      a2m_cnt_q   <= a2m_cnt_d;
      m2a_cnt_q   <= m2a_cnt_d;
      a2m_empty_q <= a2m_empty_d;
      a2m_full_q  <= a2m_full_d;
      m2a_empty_q <= m2a_empty_d;
      m2a_full_q  <= m2a_full_d;
    end
  end

endmodule

// File: tb/tb_av_mailbox_slave.sv
// Directed bench for av_mailbox_slave (DEPTH=16, WAIT_CYCLES=1); IRQ checks run when AV_MAILBOX_IRQ_EN is defined.
module tb_av_mailbox_slave;
  logic        sysclk = 1'b0;
  logic        sysreset_n;
  logic [15:0] mcu_rx_data;
  logic        mcu_rx_read;
  logic        mcu_rx_empty;
  logic [15:0] mcu_tx_data;
  logic        mcu_tx_load;
  logic        mcu_tx_full;
  logic [15:0] status_out;
`ifdef AV_MAILBOX_IRQ_EN
  logic        s_irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] rdv;

  av_mailbox_slave_if bus ();

  av_mailbox_slave #(.DEPTH(16), .WAIT_CYCLES(1)) dut (
    .sysclk       (sysclk),
    .sysreset_n   (sysreset_n),
    .bus          (bus),
    .mcu_rx_data  (mcu_rx_data),
    .mcu_rx_read  (mcu_rx_read),
    .mcu_rx_empty (mcu_rx_empty),
    .mcu_tx_data  (mcu_tx_data),
    .mcu_tx_load  (mcu_tx_load),
    .mcu_tx_full  (mcu_tx_full),
    .status_out   (status_out)
`ifdef AV_MAILBOX_IRQ_EN
    ,
    .s_irq        (s_irq)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One Avalon access; optional MCU load/read pulses land in the ACK cycle.
  task automatic av_xfer(input logic [1:0] a, input logic rd, input logic wr, input logic [15:0] wd,
                         input logic ld, input logic [15:0] ld_data, input logic rx,
                         output logic [15:0] rv);
    int nwait;
    bus.s_address = a; bus.s_read = rd; bus.s_write = wr; bus.s_writedata = wd;
    nwait = 0;
    @(negedge sysclk);
    while (bus.s_waitrequest && nwait < 20) begin
      nwait++;
      @(negedge sysclk);
    end
    check("av_wait_states", nwait, 2);
    rv = bus.s_readdata;
    mcu_tx_load = ld; mcu_tx_data = ld_data; mcu_rx_read = rx;
    @(posedge sysclk); #1;
    bus.s_read = 1'b0; bus.s_write = 1'b0;
    mcu_tx_load = 1'b0; mcu_rx_read = 1'b0;
  endtask

  task automatic av_rd(input logic [1:0] a, output logic [15:0] rv);
    av_xfer(a, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, rv);
  endtask

  task automatic av_wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] dummy;
    av_xfer(a, 1'b0, 1'b1, d, 1'b0, 16'h0, 1'b0, dummy);
  endtask

  task automatic mcu_push(input logic [15:0] d);
    mcu_tx_data = d; mcu_tx_load = 1'b1;
    @(posedge sysclk); #1;
    mcu_tx_load = 1'b0;
  endtask

  task automatic mcu_pop();
    mcu_rx_read = 1'b1;
    @(posedge sysclk); #1;
    mcu_rx_read = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sysreset_n = 1'b0;
    bus.s_address = 2'd0; bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_writedata = 16'h0;
    mcu_rx_read = 1'b0; mcu_tx_load = 1'b0; mcu_tx_data = 16'h0;
    repeat (3) @(posedge sysclk);
    #1 sysreset_n = 1'b1;

    @(negedge sysclk);
    check("rst_status_out", status_out, 16'h0005);
    check("rst_rx_empty", mcu_rx_empty, 1'b1);
    check("rst_rx_data", mcu_rx_data, 16'h0000);
    check("rst_tx_full", mcu_tx_full, 1'b0);
    check("rst_readdata", bus.s_readdata, 16'h0000);
    check("rst_waitreq", bus.s_waitrequest, 1'b0);
    @(posedge sysclk); #1;

    av_rd(2'd1, rdv);
    check("t1_status_rd", rdv, 16'h0005);

    av_wr(2'd0, 16'h1234);
    av_wr(2'd0, 16'hABCD);
    @(negedge sysclk);
    check("t2_rx_head0", mcu_rx_data, 16'h1234);
    check("t2_rx_nempty", mcu_rx_empty, 1'b0);
    @(posedge sysclk); #1;
    mcu_pop();
    @(negedge sysclk);
    check("t2_rx_head1", mcu_rx_data, 16'hABCD);
    @(posedge sysclk); #1;
    mcu_pop();
    @(negedge sysclk);
    check("t2_rx_empty", mcu_rx_empty, 1'b1);
    check("t2_rx_data0", mcu_rx_data, 16'h0000);
    @(posedge sysclk); #1;

    av_wr(2'd2, 16'h5A5A);
    av_rd(2'd2, rdv);
    check("scratch_rd", rdv, 16'h5A5A);
    av_xfer(2'd2, 1'b1, 1'b1, 16'h0F0F, 1'b0, 16'h0, 1'b0, rdv);
    check("rdwr_readdata0", rdv, 16'h0000);
    av_rd(2'd2, rdv);
    check("rdwr_is_write", rdv, 16'h0F0F);
    av_wr(2'd3, 16'hFFFF);
    av_rd(2'd3, rdv);
`ifdef AV_MAILBOX_IRQ_EN
    check("irqctl_rd", rdv, 16'h0001);
    av_wr(2'd3, 16'h0000);
`else
    check("irqctl_rd", rdv, 16'h0000);
`endif

    // a2m holds one word so STATUS bit0 is clear during the m2a fill
    av_wr(2'd0, 16'h00EE);
    for (int i = 1; i <= 17; i++) mcu_push(16'(i));
    @(negedge sysclk);
    check("t3_status_out", status_out, 16'h1048);
    check("t3_tx_full", mcu_tx_full, 1'b1);
    @(posedge sysclk); #1;
    av_rd(2'd1, rdv);
    check("t3_status_rd", rdv, 16'h1048);
    for (int i = 1; i <= 16; i++) begin
      av_rd(2'd0, rdv);
      check("t3_m2a_word", rdv, 32'(i));
    end
    av_rd(2'd0, rdv);
    check("t3_unf_word", rdv, 16'h0000);
    av_rd(2'd1, rdv);
    check("t3_status_sticky", rdv, 16'h0064);
    av_wr(2'd1, 16'h0070);
    av_rd(2'd1, rdv);
    check("t3_status_cleared", rdv, 16'h0004);

    for (int i = 1; i <= 15; i++) av_wr(2'd0, 16'h0100 + 16'(i));
    av_wr(2'd0, 16'hDEAD);
    av_rd(2'd1, rdv);
    check("a2m_ovf_status", rdv, 16'h0016);
    @(negedge sysclk);
    check("a2m_head", mcu_rx_data, 16'h00EE);
    @(posedge sysclk); #1;
    mcu_pop();
    for (int i = 1; i <= 15; i++) begin
      @(negedge sysclk);
      check("a2m_word", mcu_rx_data, 32'h0100 + 32'(i));
      @(posedge sysclk); #1;
      mcu_pop();
    end
    @(negedge sysclk);
    check("a2m_drained", status_out, 16'h0015);
    @(posedge sysclk); #1;
    av_wr(2'd1, 16'h0010);
    @(negedge sysclk);
    check("a2m_ovf_cleared", status_out, 16'h0005);
    @(posedge sysclk); #1;

    // Empty a2m: MCU pop coinciding with the push is ignored
    av_xfer(2'd0, 1'b0, 1'b1, 16'h0099, 1'b0, 16'h0, 1'b1, rdv);
    @(negedge sysclk);
    check("empty_pushpop_nempty", mcu_rx_empty, 1'b0);
    check("empty_pushpop_data", mcu_rx_data, 16'h0099);
    @(posedge sysclk); #1;
    mcu_pop();

    for (int i = 0; i < 16; i++) mcu_push(16'h0020 + 16'(i));
    av_xfer(2'd0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0030, 1'b0, rdv);
    check("t4_first", rdv, 16'h0020);
    @(negedge sysclk);
    check("t4_status", status_out, 16'h1009);
    @(posedge sysclk); #1;
    for (int i = 1; i <= 16; i++) begin
      av_rd(2'd0, rdv);
      check("t4_order", rdv, 32'h0020 + 32'(i));
    end
    @(negedge sysclk);
    check("t4_drained", status_out, 16'h0005);
    @(posedge sysclk); #1;

`ifdef AV_MAILBOX_IRQ_EN
    av_wr(2'd3, 16'h0001);
    mcu_push(16'h0042);
    @(negedge sysclk);
    check("t6_irq_lag", s_irq, 1'b0);
    @(negedge sysclk);
    check("t6_irq_set", s_irq, 1'b1);
    @(posedge sysclk); #1;
    av_rd(2'd0, rdv);
    check("t6_word", rdv, 16'h0042);
    @(negedge sysclk);
    check("t6_irq_hold", s_irq, 1'b1);
    @(negedge sysclk);
    check("t6_irq_clr", s_irq, 1'b0);
    @(posedge sysclk); #1;
`endif

    mcu_push(16'h0077);
    bus.s_address = 2'd0; bus.s_read = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    sysreset_n = 1'b0;
    @(posedge sysclk); #1;
    sysreset_n = 1'b1;
    av_rd(2'd0, rdv);
    check("t5_rd_after_rst", rdv, 16'h0000);
    @(negedge sysclk);
    check("t5_status", status_out, 16'h0025);
    @(posedge sysclk); #1;
    av_rd(2'd2, rdv);
    check("t5_scratch_rst", rdv, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
